// File: rtl/data_memory_bank.sv
// data_memory_bank: single-clock data memory between load/store and write-back.
// One read or write per cycle over a req/ack handshake, per-byte write mask,
// misaligned / out-of-range accesses answered with addrError.
// Define DATA_MEMORY_BANK_CLEAR_EN to add a post-reset zero sweep of the array.
module data_memory_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic                    writeEn,
    input  logic [DATA_WIDTH/8-1:0] byteEn,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   dataInput,
    output logic [DATA_WIDTH-1:0]   dataOutput,
    output logic                    ack,
    output logic                    addrError,
    output logic                    busy
);
    localparam int B  = DATA_WIDTH / 8;
    localparam int S  = $clog2(B);
    localparam int IW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] word_index;
    logic [IW-1:0]         idx;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  access_error;
    logic                  accept;
    logic                  write_valid;
    logic                  clearing;
    logic [IW-1:0]         clr_idx;

    assign word_index   = address >> S;
    assign idx          = word_index[IW-1:0];
    assign out_of_range = word_index >= ADDR_WIDTH'(DEPTH);

    // Byte-wide words have no sub-word offset, so they can never be misaligned.
    generate
        if (S > 0) begin : g_align
            assign misaligned = |address[S-1:0];
        end else begin : g_no_align
            assign misaligned = 1'b0;
        end
    endgenerate

    assign access_error = misaligned | out_of_range;
    assign accept       = req & ~busy;
    assign write_valid  = accept & writeEn & ~access_error;

`ifdef DATA_MEMORY_BANK_CLEAR_EN
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t state;

    assign clearing = (state == CLEAR);
`else
    assign clearing = 1'b0;
    assign clr_idx  = '0;
    assign busy     = 1'b0;
`endif

    // Storage array: the clear sweep has priority, otherwise masked byte-lane writes.
    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[clr_idx] <= '0;
        end else if (write_valid) begin
            for (int i = 0; i < B; i++) begin
                if (byteEn[i]) begin
                    mem[idx][i*8 +: 8] <= dataInput[i*8 +: 8];
                end
            end
        end
    end

    // Control: clear sequencer plus the registered ack / error / read-data response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dataOutput <= '0;
            ack        <= 1'b0;
            addrError  <= 1'b0;
`ifdef DATA_MEMORY_BANK_CLEAR_EN
            state      <= CLEAR;
            busy       <= 1'b1;
            clr_idx    <= '0;
`endif
        end else begin
            ack       <= 1'b0;
            addrError <= 1'b0;
`ifdef DATA_MEMORY_BANK_CLEAR_EN
            case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == IW'(DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    busy <= 1'b0;
                end
                default: begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                end
            endcase
`endif
            if (accept) begin
                ack <= 1'b1;
                if (access_error) begin
                    addrError  <= 1'b1;
                    dataOutput <= '0;
                end else if (!writeEn) begin
                    dataOutput <= mem[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_bank.sv
// tb_data_memory_bank: scoreboard bench for data_memory_bank.
// Main instance uses default parameters; a second 16-bit / 8-word instance
// covers the parametrised geometry. Works with or without DATA_MEMORY_BANK_CLEAR_EN.
module tb_data_memory_bank;

`ifdef DATA_MEMORY_BANK_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        writeEn;
    logic [3:0]  byteEn;
    logic [31:0] address;
    logic [31:0] dataInput;
    logic [31:0] dataOutput;
    logic        ack;
    logic        addrError;
    logic        busy;

    logic        p_req;
    logic        p_we;
    logic [1:0]  p_be;
    logic [31:0] p_addr;
    logic [15:0] p_din;
    logic [15:0] p_dout;
    logic        p_ack;
    logic        p_err;
    logic        p_busy;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [64];
    logic [31:0] model_dout;
    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    // Free-running clock
    always #5 clk = ~clk;

    data_memory_bank dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .writeEn   (writeEn),
        .byteEn    (byteEn),
        .address   (address),
        .dataInput (dataInput),
        .dataOutput(dataOutput),
        .ack       (ack),
        .addrError (addrError),
        .busy      (busy)
    );

    data_memory_bank #(.DATA_WIDTH(16), .DEPTH(8), .ADDR_WIDTH(32)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (p_req),
        .writeEn   (p_we),
        .byteEn    (p_be),
        .address   (p_addr),
        .dataInput (p_din),
        .dataOutput(p_dout),
        .ack       (p_ack),
        .addrError (p_err),
        .busy      (p_busy)
    );

    // Edge counter used to match each accepted request to its ack cycle
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic resetModel();
        model_dout = '0;
        if (CLR) begin
            for (int i = 0; i < 64; i++) model_mem[i] = '0;
        end
    endtask

    // Drive one request from a falling edge, hold it through busy, push the expectation
    task automatic applyStimulus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                 input logic [31:0] data, output int waits);
        exp_t        e;
        logic [31:0] w;
        logic        err;
        int          ix;
        req       = 1'b1;
        writeEn   = we;
        byteEn    = be;
        address   = addr;
        dataInput = data;
        waits     = 0;
        while (busy === 1'b1 && waits < 300) begin
            waits++;
            @(negedge clk);
        end
        if (busy !== 1'b0) begin
            checkOutput("busy_timeout", 32'(busy), 32'd0);
            req = 1'b0;
            return;
        end
        err = (addr[1:0] != 2'd0) || ((addr >> 2) >= 32'd64);
        ix  = int'(addr >> 2);
        if (err) begin
            model_dout = '0;
        end else if (we) begin
            w = model_mem[ix];
            for (int i = 0; i < 4; i++) begin
                if (be[i]) w[i*8 +: 8] = data[i*8 +: 8];
            end
            model_mem[ix] = w;
        end else begin
            model_dout = model_mem[ix];
        end
        e.cyc  = cyc;
        e.err  = err;
        e.data = model_dout;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req     = 1'b0;
        writeEn = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every falling edge, either an expected ack is due or ack must be low
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc < cyc - 1) begin
            sb.delete(0);
            checkOutput("ack_missing", 32'd0, 32'd1);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
            e = sb.pop_front();
            checkOutput("ack", 32'(ack), 32'd1);
            checkOutput("addr_err", 32'(addrError), 32'(e.err));
            checkOutput("dout", dataOutput, e.data);
        end else begin
            checkOutput("ack_idle", 32'(ack), 32'd0);
        end
    end

    initial begin
        int w;
        int n;
        rst_n = 1'b0; req = 1'b0; writeEn = 1'b0; byteEn = '0; address = '0; dataInput = '0;
        p_req = 1'b0; p_we = 1'b0; p_be = '0; p_addr = '0; p_din = '0;
        for (int i = 0; i < 64; i++) model_mem[i] = 'x;
        resetModel();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_dout", dataOutput, 32'd0);
        checkOutput("rst_ack", 32'(ack), 32'd0);
        checkOutput("rst_err", 32'(addrError), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'(CLR));
        @(negedge clk);
        rst_n = 1'b1;

`ifdef DATA_MEMORY_BANK_CLEAR_EN
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, w);
`else
        applyStimulus(1'b1, 4'hF, 32'h0, 32'h12345678, w);
`endif
        checkOutput("busy_wait", 32'(w), CLR ? 32'd64 : 32'd0);
        applyStimulus(1'b1, 4'hF, 32'h0, 32'h12345678, w);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, w);
        idle(1);

        applyStimulus(1'b1, 4'hF, 32'h10, 32'hAABBCCDD, w);
        applyStimulus(1'b1, 4'b0101, 32'h10, 32'h11223344, w);
        applyStimulus(1'b0, 4'h0, 32'h10, 32'h0, w);
        idle(2);

        applyStimulus(1'b1, 4'hF, 32'hFC, 32'hDEADBEEF, w);
        applyStimulus(1'b0, 4'h0, 32'hFC, 32'h0, w);
        idle(1);

        applyStimulus(1'b0, 4'h0, 32'h102, 32'h0, w);
        applyStimulus(1'b0, 4'h0, 32'h11, 32'h0, w);
        applyStimulus(1'b1, 4'hF, 32'h100, 32'hFFFFFFFF, w);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, w);
        applyStimulus(1'b1, 4'h0, 32'h0, 32'h0BADF00D, w);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, w);
        idle(1);

        // Reset in the ack cycle of a read: outputs must drop without waiting for a clock
        applyStimulus(1'b0, 4'h0, 32'h10, 32'h0, w);
        req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midacc_dout", dataOutput, 32'd0);
        checkOutput("midacc_ack", 32'(ack), 32'd0);
        checkOutput("midacc_busy", 32'(busy), 32'(CLR));
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midclr_busy", 32'(busy), 32'(CLR));
        checkOutput("midclr_ack", 32'(ack), 32'd0);
        resetModel();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 4'h0, 32'h10, 32'h0, w);
        checkOutput("busy_wait_again", 32'(w), CLR ? 32'd64 : 32'd0);
        idle(2);

        // Narrow instance: 16-bit words, 8 entries
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        resetModel();
        @(posedge clk);
        #1 checkOutput("p16_busy_first_edge", 32'(p_busy), 32'(CLR));
        n = 0;
        while (p_busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        checkOutput("p16_busy_done", 32'(p_busy), 32'd0);
        @(negedge clk);
        p_req = 1'b1; p_we = 1'b1; p_be = 2'b11; p_addr = 32'hE; p_din = 16'hBEEF;
        @(negedge clk);
        checkOutput("p16_wr_ack", 32'(p_ack), 32'd1);
        checkOutput("p16_wr_err", 32'(p_err), 32'd0);
        p_we = 1'b0;
        @(negedge clk);
        checkOutput("p16_rd_ack", 32'(p_ack), 32'd1);
        checkOutput("p16_rd_dout", 32'(p_dout), 32'h0000BEEF);
        checkOutput("p16_rd_err", 32'(p_err), 32'd0);
        p_addr = 32'h10;
        @(negedge clk);
        checkOutput("p16_oor_ack", 32'(p_ack), 32'd1);
        checkOutput("p16_oor_err", 32'(p_err), 32'd1);
        checkOutput("p16_oor_dout", 32'(p_dout), 32'd0);
        p_req = 1'b0;
        @(negedge clk);
        checkOutput("p16_idle_ack", 32'(p_ack), 32'd0);

        idle(3);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_memory_bank.md
# data_memory_bank

Parametrised, single-clock data memory for the ARM calculator datapath, sitting between the load/store stage and the register file write-back. It stores `DEPTH` words of `DATA_WIDTH` bits. It accepts one read or write per cycle through a req/ack handshake, supports per-byte write enables, and flags misaligned or out-of-range addresses. An optional post-reset clear sequencer zeroes the whole array before the first access is accepted.

## Interface
- `DATA_WIDTH`, 32, word width in bits; multiple of 8.
- `DEPTH`, 64, number of words; power of two, ≥ 2.
- `ADDR_WIDTH`, 32, byte-address width.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `req`  in  1  access request, sampled on rising edge.
- `writeEn`  in  1  1 = write, 0 = read; valid with `req`.
- `byteEn`  in  DATA_WIDTH/8  byte-lane write mask; ignored on reads.
- `address`  in  ADDR_WIDTH  byte address.
- `dataInput`  in  DATA_WIDTH  write data.
- `dataOutput`  out  DATA_WIDTH  registered read data.
- `ack`  out  1  one-cycle response pulse.
- `addrError`  out  1  qualifies `ack`; access was rejected.
- `busy`  out  1  requests are not accepted while high.

## Operation
- Let B = DATA_WIDTH/8 and S = log2(B).
- Word index = `address` >> S.
- An access is misaligned when `address`[S-1:0] ≠ 0.
- An access is out of range when the word index ≥ DEPTH.
- Either condition makes the access an error.
- Accepted access: `req`=1 and `busy`=0 at a rising edge.
- Accepted valid write:
  - For every lane i with `byteEn`[i]=1, write byte i of `dataInput` into the word.
  - Lanes with `byteEn`[i]=0 keep their old value.
  - `byteEn`=0 writes nothing but is still acknowledged.
  - `dataOutput` keeps its previous value.
- Accepted valid read: `dataOutput` ← stored word.
- Accepted error access:
  - No array change.
  - `dataOutput` ← 0.
  - `addrError`=1 together with `ack`.
- Requests arriving while `busy`=1 are dropped: no ack and no side effects. The requester must hold `req` until it sees `busy`=0.
- FSM (with clear compiled in):
  - CLEAR: write 0 to word `clrIdx` and increment `clrIdx`. After writing index DEPTH-1, go to IDLE.
  - IDLE: serve requests.
  - Without the clear feature, the FSM is permanently IDLE.

## Timing
- Reset values: `dataOutput`=0, `ack`=0, `addrError`=0.
- `busy` resets to 1 with clear, 0 without.
- `clrIdx` resets to 0.
- Latency: a request accepted at edge n gives `ack` high for exactly the cycle after edge n. Read data and `addrError` are valid in that same cycle.
- Throughput: one access per cycle, with back-to-back accesses allowed.
- Read-after-write: a write at edge n followed by a read of the same word at edge n+1 returns the new data. There is no bypass; the array is updated at edge n.
- `ack` and `addrError` deassert in any cycle without an accepted request.
- Clear duration: `busy` is high for exactly DEPTH cycles after `rst_n` release. The first request can be accepted at edge DEPTH+1 after release.
- Reset asserted mid-clear or mid-access:
  - Outputs go to reset values immediately.
  - The clear restarts from index 0 when `rst_n` is released.
  - A pending write that has not yet hit its edge is lost.
- Without clear, array contents are not affected by `rst_n`.

## Configuration
- Macro: `DATA_MEMORY_BANK_CLEAR_EN`.
- Defined:
  - Clear sequencer and `clrIdx` counter are present.
  - Every reset is followed by a DEPTH-cycle zero sweep with `busy`=1.
  - All words read 0 after the sweep.
- Undefined:
  - No sequencer; `busy` is tied to 0.
  - Accesses are accepted on the first edge after reset release.
  - Contents persist across reset; uninitialised words read as X in simulation.

## Test plan
- Clear (macro on, defaults): release `rst_n` and hold `req` with a read of 0x0 → `busy` high for 64 cycles, no ack meanwhile; then ack with `dataOutput`=0x00000000.
- Byte-lane write: write 0xAABBCCDD to 0x10 with `byteEn`=4'hF, then write 0x11223344 with `byteEn`=4'b0101, then read 0x10 → 0xAA22CC44, `addrError`=0.
- Back-to-back read-after-write:
  - Stimulus: write 0xDEADBEEF to 0xFC at edge n, then read 0xFC at edge n+1.
  - Response: ack in both following cycles; the read returns 0xDEADBEEF.
- Errors:
  - Read 0x102 → ack, `addrError`=1, `dataOutput`=0.
  - Write to 0x100 (index 64) → ack, `addrError`=1; a later read of 0x0 is unchanged.
- Reset mid-clear: assert `rst_n`=0 at clear cycle 30 → outputs reset immediately; after release `busy` is high for a full 64 cycles again.
- Parametrisation (DATA_WIDTH=16, DEPTH=8, macro off):
  - `busy`=0 from the first edge.
  - Write 0xBEEF to 0xE, then read it → 0xBEEF.
  - Read 0x10 → `addrError`=1.
